mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) round-robin arbiter onto a single-port memory
module mem_arbiter #(
  parameter int WORD    = 32,
  parameter int ADDRESS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDRESS-1:0] if_addr,
  output logic [WORD-1:0]    if_rdata,
  output logic               if_valid,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDRESS-1:0] d_addr,
  input  logic [WORD-1:0]    d_wdata,
  input  logic [1:0]         d_size,
  input  logic               d_ext,
  output logic [WORD-1:0]    d_rdata,
  output logic               d_valid,
  output logic               mem_en,
  output logic               mem_wr_en,
  output logic [ADDRESS-1:0] mem_addr,
  output logic [WORD-1:0]    mem_wdata,
  output logic [1:0]         mem_size,
  output logic               mem_ext,
  input  logic [WORD-1:0]    mem_rdata,
  output logic               stall,
  output logic [15:0]        stall_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {GNT_IF, GNT_D} port_t;
  state_t r_state;
  port_t  r_gnt;
  port_t  r_last;
  logic   w_any;
  logic   w_pick_d;
  assign w_any    = if_req | d_req;
  assign w_pick_d = d_req & (~if_req | (r_last == GNT_IF));
  assign stall    = d_req | ((r_state != IDLE) & (r_gnt == GNT_D)) | (if_req & ~if_valid);
  // Arbitration FSM; memory-side fields are latched straight into the output registers at grant
  // so they hold their last driven value outside ISSUE. mem_wr_en doubles as the latched store flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_gnt     <= GNT_IF;
      r_last    <= GNT_IF;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      mem_ext   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state   <= ISSUE;
            r_gnt     <= w_pick_d ? GNT_D : GNT_IF;
            mem_en    <= 1'b1;
            mem_wr_en <= w_pick_d & d_we;
            mem_addr  <= w_pick_d ? d_addr : if_addr;
            mem_size  <= w_pick_d ? d_size : 2'd2;
            mem_ext   <= w_pick_d & d_ext;
            if (w_pick_d) mem_wdata <= d_wdata;
          end
        end
        ISSUE: begin
          r_state   <= RESP;
          mem_en    <= 1'b0;
          mem_wr_en <= 1'b0;
          if (r_gnt == GNT_IF) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
          end else begin
            d_valid <= 1'b1;
            if (!mem_wr_en) d_rdata <= mem_rdata;
          end
        end
        RESP: begin
          r_state  <= IDLE;
          r_last   <= r_gnt;
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Saturating count of cycles in which the core is told to hold its PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_count <= '0;
    else if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end
endmodule
